// File: rtl/ad_output_formatter.sv
// ad_output_formatter
//
// Output formatting stage for the AD9970 simulation model. It sits between
// the pixel pipeline and the LVDS serialiser model and has one lane per
// output channel. The pipeline has four register levels:
//   stage 1  : per-lane source mux (pixel / fixed / ramp / toggle)
//   stage 2a : alignment delay, first register
//   stage 2b : alignment delay, second register
//   stage 3  : output register, where sync words can replace the stream
// Data sampled at edge t is on ov_pix_data after edge t+3. A sync request
// sampled at edge t puts sync word 0 on the output after edge t.
//
// Handshake: there is no backpressure. i_pix_valid qualifies iv_pix_data in
// the same cycle. o_data_valid qualifies ov_pix_data in the same cycle. Sync
// words replace any stream words that reach the output register during a
// sequence, and those stream words are lost.
//
// Build option: define AD_OUTPUT_RAMP_EN to build the ramp generator. When it
// is undefined, mode 2 gives pixel data, exactly as mode 0 does.
//
// Ports:
//   clk             pixel clock, rising edge
//   reset           synchronous, active-high
//   iv_pix_data     CH_NUM pixels; channel c is at [c*DATA_WIDTH +: DATA_WIDTH]
//   i_pix_valid     iv_pix_data is valid
//   iv_pattern_mode 0 pixel, 1 fixed, 2 ramp, 3 toggle
//   iv_lvds_pattern fixed pattern value and toggle base
//   i_sync_start    one-cycle request to start a sync sequence
//   iv_sync_word    SYNC_LEN words; word k is at [k*OUT_WIDTH +: OUT_WIDTH]
//   o_sync_busy     high while sync words 1..SYNC_LEN-1 are on the output
//   ov_pix_data     registered formatted output, CH_NUM words
//   o_data_valid    ov_pix_data is valid
module ad_output_formatter #(
  parameter int DATA_WIDTH = 14,
  parameter int OUT_WIDTH  = 16,
  parameter int CH_NUM     = 2,
  parameter int SYNC_LEN   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH*CH_NUM-1:0]   iv_pix_data,
  input  logic                           i_pix_valid,
  input  logic [1:0]                     iv_pattern_mode,
  input  logic [OUT_WIDTH-1:0]           iv_lvds_pattern,
  input  logic                           i_sync_start,
  input  logic [OUT_WIDTH*SYNC_LEN-1:0]  iv_sync_word,
  output logic                           o_sync_busy,
  output logic [OUT_WIDTH*CH_NUM-1:0]    ov_pix_data,
  output logic                           o_data_valid
);

  localparam int PW   = OUT_WIDTH * CH_NUM;
  localparam int IDXW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SYNC_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SYNC = 1'b1
  } state_t;

  logic [PW-1:0] s1_next;
  logic [PW-1:0] s1_data;
  logic          s1_valid;
  logic [PW-1:0] s2a_data;
  logic          s2a_valid;
  logic [PW-1:0] s2b_data;
  logic          s2b_valid;
  logic          toggle_ph;

  state_t        state;
  state_t        state_next;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_next;
  logic [PW-1:0] out_data;
  logic [PW-1:0] out_next;
  logic          out_valid;
  logic          out_valid_next;
  logic          busy;

  logic [OUT_WIDTH-1:0] sync_words [SYNC_LEN];

`ifdef AD_OUTPUT_RAMP_EN
  logic [OUT_WIDTH-1:0] ramp_cnt;

  // The ramp counter advances only on valid ramp-mode cycles. It keeps its
  // value across mode changes, so a ramp continues where it stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt <= '0;
    end else if (i_pix_valid && (iv_pattern_mode == 2'd2)) begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end
`endif

  // ---------------- stage 1: per-lane source mux ----------------
  for (genvar c = 0; c < CH_NUM; c++) begin : g_lane
    logic [OUT_WIDTH-1:0] pix_word;
    logic [OUT_WIDTH-1:0] lane_word;

    // The pixel is MSB-aligned in the wider output word, with zero padding
    // in the low bits.
    assign pix_word = OUT_WIDTH'(iv_pix_data[c*DATA_WIDTH +: DATA_WIDTH])
                      << (OUT_WIDTH - DATA_WIDTH);

    always_comb begin
      lane_word = pix_word;
      case (iv_pattern_mode)
        2'd1:    lane_word = iv_lvds_pattern;
`ifdef AD_OUTPUT_RAMP_EN
        2'd2:    lane_word = ramp_cnt + OUT_WIDTH'(c);
`endif
        2'd3:    lane_word = toggle_ph ? ~iv_lvds_pattern : iv_lvds_pattern;
        default: lane_word = pix_word;
      endcase
    end

    assign s1_next[c*OUT_WIDTH +: OUT_WIDTH] = lane_word;
  end

  for (genvar k = 0; k < SYNC_LEN; k++) begin : g_sync_word
    assign sync_words[k] = iv_sync_word[k*OUT_WIDTH +: OUT_WIDTH];
  end

  // ---------------- stage 1 and 2: source and alignment registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s2a_data  <= '0;
      s2a_valid <= 1'b0;
      s2b_data  <= '0;
      s2b_valid <= 1'b0;
      toggle_ph <= 1'b0;
    end else begin
      s1_data   <= s1_next;
      s1_valid  <= i_pix_valid;
      s2a_data  <= s1_data;
      s2a_valid <= s1_valid;
      s2b_data  <= s2a_data;
      s2b_valid <= s2a_valid;
      if (i_pix_valid && (iv_pattern_mode == 2'd3)) begin
        toggle_ph <= ~toggle_ph;
      end
    end
  end

  // ---------------- stage 3: sync replacement FSM ----------------
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    out_next       = s2b_data;
    out_valid_next = s2b_valid;
    case (state)
      IDLE: begin
        if (i_sync_start) begin
          out_next       = {CH_NUM{sync_words[0]}};
          out_valid_next = 1'b1;
          if (SYNC_LEN > 1) begin
            state_next = SYNC;
            idx_next   = IDXW'(1);
          end
        end
      end
      SYNC: begin
        // A new start request is ignored here and is not queued.
        out_next       = {CH_NUM{sync_words[idx]}};
        out_valid_next = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // busy is registered next to the output word, so it is high exactly while
  // words 1..SYNC_LEN-1 are on ov_pix_data. The FSM is in SYNC on the edge
  // that loads each of those words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      out_data  <= out_next;
      out_valid <= out_valid_next;
      busy      <= (state == SYNC);
    end
  end

  assign ov_pix_data  = out_data;
  assign o_data_valid = out_valid;
  assign o_sync_busy  = busy;

endmodule

// File: tb/tb_ad_output_formatter.sv
// Testbench for ad_output_formatter with the default parameters
// (DATA_WIDTH=14, OUT_WIDTH=16, CH_NUM=2, SYNC_LEN=4).
// The stimulus thread pushes each expected {busy, ch1, ch0} word when it
// issues the matching stimulus. The monitor pops and compares one word on
// every cycle where o_data_valid is high. Directed checks cover the reset
// state and the exact latency.
// Compile with +define+AD_OUTPUT_RAMP_EN to test the ramp pattern.
module tb_ad_output_formatter;
  localparam int DW = 14;
  localparam int OW = 16;
  localparam int CN = 2;
  localparam int SL = 4;
  localparam int PW = OW * CN;
  localparam int W  = PW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW*CN-1:0] iv_pix_data;
  logic            i_pix_valid;
  logic [1:0]      iv_pattern_mode;
  logic [OW-1:0]   iv_lvds_pattern;
  logic            i_sync_start;
  logic [OW*SL-1:0] iv_sync_word;
  logic            o_sync_busy;
  logic [PW-1:0]   ov_pix_data;
  logic            o_data_valid;

  ad_output_formatter #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CH_NUM(CN), .SYNC_LEN(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iv_pix_data(iv_pix_data),
    .i_pix_valid(i_pix_valid),
    .iv_pattern_mode(iv_pattern_mode),
    .iv_lvds_pattern(iv_lvds_pattern),
    .i_sync_start(i_sync_start),
    .iv_sync_word(iv_sync_word),
    .o_sync_busy(o_sync_busy),
    .ov_pix_data(ov_pix_data),
    .o_data_valid(o_data_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] pk(input logic b, input logic [OW-1:0] c0,
                                      input logic [OW-1:0] c1);
    return {b, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive at the negedge. The DUT samples at the next posedge, and the task
  // returns at the following negedge.
  task automatic step(input logic [1:0] m, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic v, input logic s);
    iv_pattern_mode = m;
    iv_pix_data     = {d1, d0};
    i_pix_valid     = v;
    i_sync_start    = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_sync();
    exp_q.push_back(pk(1'b0, 16'hFFFF, 16'hFFFF));
    exp_q.push_back(pk(1'b1, 16'h0000, 16'h0000));
    exp_q.push_back(pk(1'b1, 16'h0000, 16'h0000));
    exp_q.push_back(pk(1'b1, 16'hAB00, 16'hAB00));
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (o_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h expected no valid word",
                   {o_sync_busy, ov_pix_data});
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", {o_sync_busy, ov_pix_data}, e);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    iv_pix_data     = '0;
    i_pix_valid     = 1'b0;
    iv_pattern_mode = 2'd0;
    iv_lvds_pattern = 16'hA5A5;
    i_sync_start    = 1'b0;
    iv_sync_word    = {16'hAB00, 16'h0000, 16'h0000, 16'hFFFF};

    fork
      monitor();
    join_none

    @(negedge clk);                       // after edge 1
    chk("reset_out", {o_sync_busy, ov_pix_data}, '0);
    chk("reset_valid", W'(o_data_valid), '0);
    @(negedge clk);                       // after edge 2
    reset = 1'b0;
    @(negedge clk);                       // edge 3
    @(negedge clk);                       // edge 4

    // Mode 0: the pixel is sampled at edge 5 and is on the output after edge 8.
    exp_q.push_back(pk(1'b0, 16'h6AF0, 16'h048C));
    step(2'd0, 14'h1ABC, 14'h0123, 1'b1, 1'b0);   // edge 5
    step(2'd0, '0, '0, 1'b0, 1'b0);               // edge 6
    @(negedge clk);                               // edge 7
    chk("lat_e7_valid", W'(o_data_valid), '0);
    @(negedge clk);                               // edge 8
    chk("lat_e8_valid", W'(o_data_valid), W'(1));
    chk("lat_e8_data", W'(ov_pix_data), W'({16'h048C, 16'h6AF0}));
    @(negedge clk);                               // edge 9
    chk("lat_e9_valid", W'(o_data_valid), '0);

    // More mode 0 vectors, including all-ones and all-zeros pixels.
    exp_q.push_back(pk(1'b0, 16'hFFFC, 16'h0000));
    step(2'd0, 14'h3FFF, 14'h0000, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h0004, 16'hAAA8));
    step(2'd0, 14'h0001, 14'h2AAA, 1'b1, 1'b0);

    // Mode 1: the fixed pattern on all lanes, changing mode with back-to-back valid cycles.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(1'b0, 16'hA5A5, 16'hA5A5));
      step(2'd1, 14'h1234, 14'h0567, 1'b1, 1'b0);
    end

    // Mode 3: the toggle pattern. A cycle with no valid input must not flip the phase.
    exp_q.push_back(pk(1'b0, 16'hA5A5, 16'hA5A5));
    step(2'd3, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h5A5A, 16'h5A5A));
    step(2'd3, '0, '0, 1'b1, 1'b0);
    step(2'd3, '0, '0, 1'b0, 1'b0);
    exp_q.push_back(pk(1'b0, 16'hA5A5, 16'hA5A5));
    step(2'd3, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h5A5A, 16'h5A5A));
    step(2'd3, '0, '0, 1'b1, 1'b0);
    idle(5);

    // Mode 2.
`ifdef AD_OUTPUT_RAMP_EN
    // Bring the ramp from 0 up to FFFE, then check the wrap directly.
    for (int n = 0; n < 65534; n++) begin
      exp_q.push_back(pk(1'b0, OW'(n), OW'(n + 1)));
      step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
    end
    exp_q.push_back(pk(1'b0, 16'hFFFE, 16'hFFFF));
    step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'hFFFF, 16'h0000));
    step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h0000, 16'h0001));
    step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h0001, 16'h0002));
    step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
`else
    // Without the ramp, mode 2 gives pixel data.
    exp_q.push_back(pk(1'b0, 16'h3FFC, 16'hC000));
    step(2'd2, 14'h0FFF, 14'h3000, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h48D0, 16'h8004));
    step(2'd2, 14'h1234, 14'h2001, 1'b1, 1'b0);
    exp_q.push_back(pk(1'b0, 16'h4444, 16'h8888));
    step(2'd2, 14'h1111, 14'h2222, 1'b1, 1'b0);
`endif
    idle(5);

    // Sync A: the pixel sampled at edge t is lost, and the pixel at t+1 follows the sync words.
    push_sync();
    step(2'd0, 14'h0055, 14'h00AA, 1'b1, 1'b1);   // edge t
    exp_q.push_back(pk(1'b0, 16'h0404, 16'h0808));
    step(2'd0, 14'h0101, 14'h0202, 1'b1, 1'b0);   // edge t+1
    idle(6);

    // Sync B: a start at t+2 is ignored, and a start at t+4 begins a new sequence.
    push_sync();
    step(2'd0, '0, '0, 1'b0, 1'b1);               // t
    step(2'd0, '0, '0, 1'b0, 1'b0);               // t+1
    step(2'd0, '0, '0, 1'b0, 1'b1);               // t+2, ignored
    step(2'd0, '0, '0, 1'b0, 1'b0);               // t+3
    push_sync();
    step(2'd0, '0, '0, 1'b0, 1'b1);               // t+4
    idle(6);

    // Reset at edge t+2 aborts the sequence.
    exp_q.push_back(pk(1'b0, 16'hFFFF, 16'hFFFF));
    exp_q.push_back(pk(1'b1, 16'h0000, 16'h0000));
    step(2'd0, '0, '0, 1'b0, 1'b1);               // t
    step(2'd0, '0, '0, 1'b0, 1'b0);               // t+1
    reset = 1'b1;
    step(2'd0, '0, '0, 1'b0, 1'b0);               // t+2
    chk("abort_out", {o_sync_busy, ov_pix_data}, '0);
    chk("abort_valid", W'(o_data_valid), '0);
    reset = 1'b0;
    step(2'd0, '0, '0, 1'b0, 1'b0);               // t+3
    chk("abort_idle_valid", W'({o_sync_busy, o_data_valid}), '0);
    exp_q.push_back(pk(1'b0, 16'h4D5C, 16'h91A0));
    step(2'd0, 14'h1357, 14'h2468, 1'b1, 1'b0);   // r
    step(2'd0, '0, '0, 1'b0, 1'b0);               // r+1
    step(2'd0, '0, '0, 1'b0, 1'b0);               // r+2
    chk("post_reset_r2_valid", W'(o_data_valid), '0);
    @(negedge clk);                               // r+3
    chk("post_reset_r3_valid", W'(o_data_valid), W'(1));
    chk("post_reset_r3_data", W'(ov_pix_data), W'({16'h91A0, 16'h4D5C}));

    // Drain the queue, with a bound on the wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", W'(exp_q.size()), '0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
